// File: rtl/fifo_read.sv
// rtl/fifo_read.sv - packet consumer that drains and checks one framed packet per fs/fd transaction
//
// Purpose: reads data_len bytes from a standard (non-FWFT) FIFO, checks the
// fixed framing HEAD0 HEAD1 <part hi> <part lo> 04 05 ... and reports the
// captured part field, a sticky error flag and a saturating mismatch count.
//
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   fifo_empty    FIFO empty flag
//   fifo_rxd      FIFO read data, valid the cycle after fifo_rxen
//   fifo_rxen     FIFO read enable
//   fs            start request, held high for the whole transaction
//   fd            done, high while in LAST
//   data_len      packet length in bytes, sampled in PREP
//   part          part field captured from bytes 2 (hi) and 3 (lo)
//   err           sticky mismatch flag for the current/last packet
//   so            mismatch count, saturating at 8'hFF
module fifo_read #(
  parameter logic [7:0] HEAD0 = 8'h66,
  parameter logic [7:0] HEAD1 = 8'hBB
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_rxd,
  output logic        fifo_rxen,
  input  logic        fs,
  output logic        fd,
  input  logic [11:0] data_len,
  output logic [15:0] part,
  output logic        err,
  output logic [7:0]  so
);

  localparam logic [7:0] S_IDLE  = 8'h01;
  localparam logic [7:0] S_PREP  = 8'h02;
  localparam logic [7:0] S_WORK  = 8'h04;
  localparam logic [7:0] S_LAST  = 8'h08;
  localparam logic [7:0] S_CHECK = 8'h20;

  logic [7:0]  state;
  logic [7:0]  state_nxt;
  logic [11:0] len_r;
  logic [11:0] req_num;
  logic [11:0] rx_num;
  logic        rx_vld;
  logic [7:0]  exp_byte;
  logic        byte_bad;
  logic        last_byte;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // The len_r guard keeps len_r-1 from wrapping to 12'hFFF on an empty packet.
  always_comb begin
    last_byte = rx_vld && (len_r != 12'd0) && (rx_num == len_r - 12'd1);
  end

  // Next-state logic; fs low anywhere before LAST aborts straight to IDLE.
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:  state_nxt = fs ? S_PREP : S_IDLE;
      S_PREP:  state_nxt = fs ? S_CHECK : S_IDLE;
      S_CHECK: begin
        if (!fs)                 state_nxt = S_IDLE;
        else if (len_r == 12'd0) state_nxt = S_LAST;
        else                     state_nxt = S_WORK;
      end
      S_WORK: begin
        if (!fs)           state_nxt = S_IDLE;
        else if (last_byte) state_nxt = S_LAST;
        else               state_nxt = S_WORK;
      end
      S_LAST:  state_nxt = fs ? S_LAST : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state; reads are gated by WORK so an abort stops them at once.
  always_comb begin
    fifo_rxen = (state == S_WORK) && !fifo_empty && (req_num < len_r);
    fd        = (state == S_LAST);
  end

  // Expected byte for the current index; indices past 255 wrap on the low byte.
  always_comb begin
    if (rx_num == 12'd0)      exp_byte = HEAD0;
    else if (rx_num == 12'd1) exp_byte = HEAD1;
    else                      exp_byte = rx_num[7:0];
    byte_bad = (fifo_rxd != exp_byte);
  end

  // Datapath. Bytes landing after leaving WORK (abort) are simply ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_r   <= 12'd0;
      req_num <= 12'd0;
      rx_num  <= 12'd0;
      rx_vld  <= 1'b0;
      err     <= 1'b0;
      so      <= 8'd0;
      part    <= 16'd0;
    end else begin
      rx_vld <= fifo_rxen;
      if (state == S_PREP) begin
        len_r   <= data_len;
        req_num <= 12'd0;
        rx_num  <= 12'd0;
        rx_vld  <= 1'b0;
        err     <= 1'b0;
        so      <= 8'd0;
      end else if (state == S_WORK) begin
        if (fifo_rxen) req_num <= req_num + 12'd1;
        if (rx_vld) begin
          rx_num <= rx_num + 12'd1;
          if (rx_num == 12'd2) begin
            part[15:8] <= fifo_rxd;
          end else if (rx_num == 12'd3) begin
            part[7:0] <= fifo_rxd;
          end else if (byte_bad) begin
            err <= 1'b1;
            if (so != 8'hFF) so <= so + 8'd1;
          end
        end
      end
    end
  end

endmodule
